// File: rtl/bus_arb_pkg.sv
// rtl/bus_arb_pkg.sv - shared types and constants for the system bus arbiter
// Purpose : arbiter state encoding, ID width for the largest master count,
//           default timeout and grant enable/disable levels used by bus blocks.
// Ports   : none (package).
package bus_arb_pkg;

   typedef enum logic {
      ARB_IDLE  = 1'b0,
      ARB_OWNED = 1'b1
   } arb_state_t;

   localparam int ARB_MAX_MASTERS        = 8;
   localparam int ARB_ID_W               = $clog2(ARB_MAX_MASTERS);
   localparam int ARB_TIMEOUT_CYCLES_DEF = 256;

   localparam logic GRNT_EN  = 1'b1;
   localparam logic GRNT_DIS = 1'b0;

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// rtl/bus_arbiter_rr_pick.sv - combinational round-robin winner picker
// Purpose : first eligible requester at or after start_i (wrapping), as one-hot.
// Ports   : req_i     - request vector
//           start_i   - index where the search begins
//           excl_i    - mask of masters not eligible this edge
//           onehot_o  - one-hot winner (zero if none)
//           found_o   - a winner exists
module rr_pick
   import bus_arb_pkg::*;
#(
   parameter int NUM_MASTERS = 4
) (
   input  logic [NUM_MASTERS-1:0]         req_i,
   input  logic [$clog2(NUM_MASTERS)-1:0] start_i,
   input  logic [NUM_MASTERS-1:0]         excl_i,
   output logic [NUM_MASTERS-1:0]         onehot_o,
   output logic                           found_o
);

   logic [NUM_MASTERS-1:0]   elig;
   logic [2*NUM_MASTERS-1:0] dbl_req;
   logic [NUM_MASTERS-1:0]   rot_req;
   logic [NUM_MASTERS-1:0]   rot_win;
   logic [2*NUM_MASTERS-1:0] dbl_win;

   assign elig    = req_i & ~excl_i;
   // Rotate so that bit 0 is master start_i, take the lowest set bit, rotate back.
   assign dbl_req = {elig, elig} >> start_i;
   assign rot_req = dbl_req[NUM_MASTERS-1:0];
   assign rot_win = rot_req & (~rot_req + 1'b1);
   assign dbl_win = {rot_win, rot_win} << start_i;

   assign onehot_o = dbl_win[2*NUM_MASTERS-1:NUM_MASTERS];
   assign found_o  = |rot_req;

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - round-robin system bus arbiter with hold-until-release
// Purpose : grants one of NUM_MASTERS masters; owner keeps the bus until it drops
//           its request. Optional forced release after TIMEOUT_CYCLES under
//           contention when BUS_ARB_TIMEOUT_EN is defined.
// Ports   : clk           - bus clock
//           reset         - asynchronous active-low reset
//           m_req         - per-master request level
//           m_grnt        - registered one-hot (or zero) grant
//           grnt_valid    - any grant bit set
//           grnt_id       - index of current owner, 0 when none
//           timeout_pulse - one-cycle strobe on forced release (BUS_ARB_TIMEOUT_EN only)
module bus_arbiter
   import bus_arb_pkg::*;
#(
   parameter int NUM_MASTERS    = 4,
   parameter int TIMEOUT_CYCLES = ARB_TIMEOUT_CYCLES_DEF
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [NUM_MASTERS-1:0]         m_req,
   output logic [NUM_MASTERS-1:0]         m_grnt,
   output logic                           grnt_valid,
   output logic [$clog2(NUM_MASTERS)-1:0] grnt_id
`ifdef BUS_ARB_TIMEOUT_EN
   ,
   output logic                           timeout_pulse
`endif
);

   localparam int ID_W = $clog2(NUM_MASTERS);

   if (NUM_MASTERS < 2 || NUM_MASTERS > ARB_MAX_MASTERS || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
      $error("bus_arbiter: illegal NUM_MASTERS or TIMEOUT_CYCLES");
   end

   arb_state_t             state_q;
   logic [NUM_MASTERS-1:0] m_grnt_q;
   logic                   grnt_valid_q;
   logic [ID_W-1:0]        grnt_id_q;
   logic [ID_W-1:0]        last_id_q;

   logic [ID_W-1:0]        start_idx;
   logic [NUM_MASTERS-1:0] pick_onehot;
   logic                   pick_found;
   logic [ID_W-1:0]        pick_id;
   logic                   owner_req;
   logic                   force_rel;

   assign owner_req = |(m_req & m_grnt_q);
   // Owner and last_id coincide while OWNED, so one start index serves both states.
   assign start_idx = (last_id_q == ID_W'(NUM_MASTERS - 1)) ? '0 : last_id_q + ID_W'(1);

   // Excluding the current grant keeps a releasing (or timed-out) owner out of this edge.
   rr_pick #(
      .NUM_MASTERS (NUM_MASTERS)
   ) u_rr_pick (
      .req_i    (m_req),
      .start_i  (start_idx),
      .excl_i   (m_grnt_q),
      .onehot_o (pick_onehot),
      .found_o  (pick_found)
   );

   always_comb begin
      pick_id = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (pick_onehot[i]) pick_id = ID_W'(i);
      end
   end

`ifdef BUS_ARB_TIMEOUT_EN
   localparam int              CNT_W   = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q;
   logic             timeout_pulse_q;

   assign force_rel     = (cnt_q == CNT_MAX) && owner_req && |(m_req & ~m_grnt_q);
   assign timeout_pulse = timeout_pulse_q;
`else
   assign force_rel = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= ARB_IDLE;
         m_grnt_q     <= '0;
         grnt_valid_q <= GRNT_DIS;
         grnt_id_q    <= '0;
         last_id_q    <= ID_W'(NUM_MASTERS - 1);
`ifdef BUS_ARB_TIMEOUT_EN
         cnt_q           <= '0;
         timeout_pulse_q <= 1'b0;
`endif
      end else begin
`ifdef BUS_ARB_TIMEOUT_EN
         timeout_pulse_q <= force_rel;
`endif
         case (state_q)
            ARB_IDLE: begin
               if (pick_found) begin
                  state_q      <= ARB_OWNED;
                  m_grnt_q     <= pick_onehot;
                  grnt_valid_q <= GRNT_EN;
                  grnt_id_q    <= pick_id;
                  last_id_q    <= pick_id;
`ifdef BUS_ARB_TIMEOUT_EN
                  cnt_q        <= '0;
`endif
               end
            end
            ARB_OWNED: begin
               if (!owner_req || force_rel) begin
                  if (pick_found) begin
                     m_grnt_q     <= pick_onehot;
                     grnt_valid_q <= GRNT_EN;
                     grnt_id_q    <= pick_id;
                     last_id_q    <= pick_id;
                  end else begin
                     state_q      <= ARB_IDLE;
                     m_grnt_q     <= '0;
                     grnt_valid_q <= GRNT_DIS;
                     grnt_id_q    <= '0;
                  end
`ifdef BUS_ARB_TIMEOUT_EN
                  cnt_q <= '0;
`endif
               end else begin
`ifdef BUS_ARB_TIMEOUT_EN
                  // Saturates so a lone owner is never forced off.
                  if (cnt_q != CNT_MAX) cnt_q <= cnt_q + CNT_W'(1);
`endif
               end
            end
         endcase
      end
   end

   assign m_grnt     = m_grnt_q;
   assign grnt_valid = grnt_valid_q;
   assign grnt_id    = grnt_id_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - directed self-checking bench for bus_arbiter
module tb_bus_arbiter;

   logic       clk;
   logic       reset;
   logic [3:0] m_req;
   logic [3:0] m_grnt;
   logic       grnt_valid;
   logic [1:0] grnt_id;
`ifdef BUS_ARB_TIMEOUT_EN
   logic       timeout_pulse;
`endif

   int errors;
   int checks;

   bus_arbiter #(
      .NUM_MASTERS    (4),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .m_req      (m_req),
      .m_grnt     (m_grnt),
      .grnt_valid (grnt_valid),
      .grnt_id    (grnt_id)
`ifdef BUS_ARB_TIMEOUT_EN
      ,
      .timeout_pulse (timeout_pulse)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      m_req = 4'b0000;
      #3;
      checks++;
      if (m_grnt !== 4'b0000 || grnt_valid !== 1'b0 || grnt_id !== 2'd0) begin
         errors++;
         $display("FAIL reset_state: got grnt=%b valid=%b id=%0d want grnt=0000 valid=0 id=0", m_grnt, grnt_valid, grnt_id);
      end
      tick();
      #2;
      reset = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if (m_grnt !== 4'b0000 || grnt_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_req cycle %0d: got grnt=%b valid=%b want grnt=0000 valid=0", i, m_grnt, grnt_valid);
         end
      end
   endtask

   task automatic test_rotate();
      logic [3:0] exp;
      m_req = 4'b1111;
      tick();
      for (int k = 0; k < 5; k++) begin
         exp = 4'b0001 << (k % 4);
         checks++;
         if (m_grnt !== exp || grnt_valid !== 1'b1 || grnt_id !== 2'(k % 4)) begin
            errors++;
            $display("FAIL rotate_grant %0d: got grnt=%b valid=%b id=%0d want grnt=%b valid=1 id=%0d", k, m_grnt, grnt_valid, grnt_id, exp, k % 4);
         end
         if (k == 4) break;
         for (int h = 0; h < 2; h++) begin
            tick();
            checks++;
            if (m_grnt !== exp) begin
               errors++;
               $display("FAIL rotate_hold %0d.%0d: got grnt=%b want %b", k, h, m_grnt, exp);
            end
         end
         m_req = 4'b1111 & ~exp;
         tick();
         m_req = 4'b1111;
      end
      m_req = 4'b0000;
      tick();
      checks++;
      if (m_grnt !== 4'b0000 || grnt_valid !== 1'b0 || grnt_id !== 2'd0) begin
         errors++;
         $display("FAIL release_to_idle: got grnt=%b valid=%b id=%0d want grnt=0000 valid=0 id=0", m_grnt, grnt_valid, grnt_id);
      end
   endtask

   task automatic test_rerequest_gap();
      m_req = 4'b0100;
      tick();
      checks++;
      if (m_grnt !== 4'b0100 || grnt_id !== 2'd2) begin
         errors++;
         $display("FAIL gap_first_grant: got grnt=%b id=%0d want grnt=0100 id=2", m_grnt, grnt_id);
      end
      m_req = 4'b0000;
      tick();
      checks++;
      if (m_grnt !== 4'b0000 || grnt_valid !== 1'b0) begin
         errors++;
         $display("FAIL gap_idle_cycle: got grnt=%b valid=%b want grnt=0000 valid=0", m_grnt, grnt_valid);
      end
      m_req = 4'b0100;
      tick();
      checks++;
      if (m_grnt !== 4'b0100 || grnt_valid !== 1'b1) begin
         errors++;
         $display("FAIL gap_regrant: got grnt=%b valid=%b want grnt=0100 valid=1", m_grnt, grnt_valid);
      end
   endtask

   task automatic test_wrap();
      m_req = 4'b1000;
      tick();
      checks++;
      if (m_grnt !== 4'b1000 || grnt_id !== 2'd3) begin
         errors++;
         $display("FAIL handoff_to_3: got grnt=%b id=%0d want grnt=1000 id=3", m_grnt, grnt_id);
      end
      m_req = 4'b0011;
      tick();
      checks++;
      if (m_grnt !== 4'b0001 || grnt_id !== 2'd0) begin
         errors++;
         $display("FAIL wrap_to_0: got grnt=%b id=%0d want grnt=0001 id=0", m_grnt, grnt_id);
      end
      tick();
      checks++;
      if (m_grnt !== 4'b0001) begin
         errors++;
         $display("FAIL owner_ignores_others: got grnt=%b want 0001", m_grnt);
      end
      m_req = 4'b0010;
      tick();
      checks++;
      if (m_grnt !== 4'b0010 || grnt_id !== 2'd1) begin
         errors++;
         $display("FAIL handoff_to_1: got grnt=%b id=%0d want grnt=0010 id=1", m_grnt, grnt_id);
      end
   endtask

   task automatic test_reset_mid();
      #3;
      reset = 1'b0;
      #1;
      checks++;
      if (m_grnt !== 4'b0000 || grnt_valid !== 1'b0 || grnt_id !== 2'd0) begin
         errors++;
         $display("FAIL async_reset_drop: got grnt=%b valid=%b id=%0d want grnt=0000 valid=0 id=0", m_grnt, grnt_valid, grnt_id);
      end
      m_req = 4'b1010;
      #2;
      reset = 1'b1;
      tick();
      checks++;
      if (m_grnt !== 4'b0010 || grnt_id !== 2'd1) begin
         errors++;
         $display("FAIL post_reset_first: got grnt=%b id=%0d want grnt=0010 id=1", m_grnt, grnt_id);
      end
   endtask

`ifdef BUS_ARB_TIMEOUT_EN
   task automatic test_timeout();
      m_req = 4'b0000;
      tick();
      m_req = 4'b0010;
      tick();
      checks++;
      if (m_grnt !== 4'b0010 || timeout_pulse !== 1'b0) begin
         errors++;
         $display("FAIL to_grant_1: got grnt=%b pulse=%b want grnt=0010 pulse=0", m_grnt, timeout_pulse);
      end
      m_req = 4'b0110;
      for (int i = 1; i < 8; i++) begin
         tick();
         checks++;
         if (m_grnt !== 4'b0010 || timeout_pulse !== 1'b0) begin
            errors++;
            $display("FAIL to_hold cycle %0d: got grnt=%b pulse=%b want grnt=0010 pulse=0", i, m_grnt, timeout_pulse);
         end
      end
      tick();
      checks++;
      if (m_grnt !== 4'b0100 || timeout_pulse !== 1'b1) begin
         errors++;
         $display("FAIL to_forced: got grnt=%b pulse=%b want grnt=0100 pulse=1", m_grnt, timeout_pulse);
      end
      tick();
      checks++;
      if (m_grnt !== 4'b0100 || timeout_pulse !== 1'b0) begin
         errors++;
         $display("FAIL to_pulse_once: got grnt=%b pulse=%b want grnt=0100 pulse=0", m_grnt, timeout_pulse);
      end
      m_req = 4'b0010;
      tick();
      checks++;
      if (m_grnt !== 4'b0010) begin
         errors++;
         $display("FAIL to_alone_grant: got grnt=%b want 0010", m_grnt);
      end
      for (int i = 0; i < 20; i++) begin
         tick();
         checks++;
         if (m_grnt !== 4'b0010 || timeout_pulse !== 1'b0) begin
            errors++;
            $display("FAIL to_alone_hold cycle %0d: got grnt=%b pulse=%b want grnt=0010 pulse=0", i, m_grnt, timeout_pulse);
         end
      end
   endtask
`else
   task automatic test_no_timeout();
      m_req = 4'b0110;
      for (int i = 0; i < 20; i++) begin
         tick();
         checks++;
         if (m_grnt !== 4'b0010) begin
            errors++;
            $display("FAIL hold_forever cycle %0d: got grnt=%b want 0010", i, m_grnt);
         end
      end
   endtask
`endif

   initial begin
      errors = 0;
      checks = 0;
      test_reset();
      test_rotate();
      test_rerequest_gap();
      test_wrap();
      test_reset_mid();
`ifdef BUS_ARB_TIMEOUT_EN
      test_timeout();
`else
      test_no_timeout();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
